// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
package uart_pkg;
    localparam int UCSZ_MIN   = 5;
    localparam int UCSZ_MAX   = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_READY
    } tx_state_e;

    // Out-of-range character sizes fall back to the widest legal size.
    function automatic logic [3:0] eff_size(input logic [3:0] ucsz);
        return (ucsz >= 4'(UCSZ_MIN) && ucsz <= 4'(UCSZ_MAX)) ? ucsz : 4'(UCSZ_MAX);
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pushes while full are ignored.
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign count   = wptr - rptr;
    // full is evaluated before any same-cycle pop, so a push at full is always dropped
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_tx_queue.sv
// CPU-side transmit queue feeding a UART data register, one byte per tx_ready handshake.
// Optional sticky overflow flag when UART_TX_QUEUE_OVF_EN is defined.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [3:0]              ucsz,
    input  logic                    tx_ready,
    output logic [DATA_W-1:0]       udrt,
    output logic                    tx_en,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef UART_TX_QUEUE_OVF_EN
    ,
    output logic                    ovf
`endif
);
    tx_state_e         state;
    tx_state_e         state_nxt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] mask;
    logic              pop;

    uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign pop  = (state == LOAD);
    assign mask = ~({DATA_W{1'b1}} << eff_size(ucsz));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (!empty && tx_ready) state_nxt = LOAD;
            LOAD:       state_nxt = WAIT_BUSY;
            WAIT_BUSY:  if (!tx_ready) state_nxt = WAIT_READY;
            WAIT_READY: if (tx_ready) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            udrt  <= '0;
            tx_en <= 1'b0;
        end else begin
            state <= state_nxt;
            tx_en <= !empty || (state != IDLE);
            if (state == LOAD) udrt <= head & mask;
        end
    end

`ifdef UART_TX_QUEUE_OVF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)              ovf <= 1'b0;
        else if (wr_en && full)  ovf <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized and directed bench for uart_tx_queue against a queue-based reference model.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [3:0] ucsz;
    logic       tx_ready;
    logic [7:0] udrt;
    logic       tx_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
`ifdef UART_TX_QUEUE_OVF_EN
    logic       ovf;
`endif

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ucsz     (ucsz),
        .tx_ready (tx_ready),
        .udrt     (udrt),
        .tx_en    (tx_en),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef UART_TX_QUEUE_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a byte queue plus the handshake progress after each load.
    logic [7:0] mq[$];
    bit         m_load_pend, m_need_low, m_need_high;
    bit         m_txen, m_ovf, m_loaded_now;
    logic [7:0] m_udrt;

    function automatic logic [7:0] trim(input logic [7:0] v, input logic [3:0] sz);
        int n;
        n = (sz >= 5 && sz <= 8) ? int'(sz) : 8;
        return 8'(int'(v) % (1 << n));
    endfunction

    always @(posedge clk) begin
        int  sz;
        bit  busy;
        m_loaded_now = 1'b0;
        if (!rst_n) begin
            mq.delete();
            m_load_pend = 0; m_need_low = 0; m_need_high = 0;
            m_txen = 0; m_ovf = 0; m_udrt = 8'h00;
        end else begin
            sz   = mq.size();
            busy = m_load_pend || m_need_low || m_need_high;
            m_txen = (sz != 0) || busy;
            if (m_load_pend) begin
                m_udrt = trim(mq.pop_front(), ucsz);
                m_load_pend = 0; m_need_low = 1; m_loaded_now = 1;
            end else if (m_need_low) begin
                if (!tx_ready) begin m_need_low = 0; m_need_high = 1; end
            end else if (m_need_high) begin
                if (tx_ready) m_need_high = 0;
            end else if (sz != 0 && tx_ready) begin
                m_load_pend = 1;
            end
            if (wr_en) begin
                if (sz < DEPTH) mq.push_back(wr_data);
                else m_ovf = 1;
            end
        end
    end

    logic [7:0] dut_log[$];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("cyc_count", count, mq.size());
        chk("cyc_empty", empty, mq.size() == 0);
        chk("cyc_full",  full,  mq.size() == DEPTH);
        chk("cyc_udrt",  udrt,  m_udrt);
        chk("cyc_tx_en", tx_en, m_txen);
`ifdef UART_TX_QUEUE_OVF_EN
        chk("cyc_ovf",   ovf,   m_ovf);
`endif
        if (m_loaded_now) dut_log.push_back(udrt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_en = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        string msg;
        msg = "Hello world!";
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ucsz = 4'd8; tx_ready = 1'b0;
        @(negedge clk);
        step();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full,  0);
        chk("rst_udrt",  udrt,  0);
        chk("rst_tx_en", tx_en, 0);
        rst_n = 1'b1;

        // "Hello world!" with a UART-like ready toggle
        dut_log.delete();
        for (int c = 0; c < 150; c++) begin
            tx_ready = (c % 6) < 3;
            if (c < 12) begin wr_en = 1'b1; wr_data = msg[c]; end
            else wr_en = 1'b0;
            step();
        end
        chk("hello_n", dut_log.size(), 12);
        for (int i = 0; i < 12; i++)
            chk("hello_byte", (i < dut_log.size()) ? {24'h0, dut_log[i]} : 32'hDEAD, {24'h0, msg[i]});
        chk("hello_empty", empty, 1);

        // overflow with the transmitter stalled, then push at full during a pop
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
        chk("ovf_count", count, 16);
        chk("ovf_full",  full,  1);
`ifdef UART_TX_QUEUE_OVF_EN
        chk("ovf_flag",  ovf,   1);
`endif
        tx_ready = 1'b1;
        step();
        push(8'hEE);
        chk("full_pushpop_count", count, 15);
        chk("full_pushpop_full",  full,  0);

        // character-size masking
        do_reset();
        ucsz = 4'd5; tx_ready = 1'b1;
        push(8'hFF);
        step(); step();
        chk("ucsz5", udrt, 8'h1F);
        tx_ready = 1'b0; step();
        tx_ready = 1'b1; step();
        ucsz = 4'd9;
        push(8'hA5);
        repeat (3) step();
        chk("ucsz9", udrt, 8'hA5);
        ucsz = 4'd8;

        // load latency and one load per handshake
        do_reset();
        tx_ready = 1'b1;
        push(8'h3C);
        step();
        chk("lat_1cyc", udrt, 8'h00);
        step();
        chk("lat_2cyc", udrt, 8'h3C);
        push(8'h7E);
        repeat (10) step();
        chk("no_reload_udrt",  udrt,  8'h3C);
        chk("no_reload_count", count, 1);
        tx_ready = 1'b0; step();
        tx_ready = 1'b1;
        repeat (4) step();
        chk("reload_udrt", udrt, 8'h7E);

        // reset mid-handshake with bytes queued
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
        chk("mid_count", count, 3);
        chk("mid_tx_en", tx_en, 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_udrt",  udrt,  0);
        chk("mid_rst_tx_en", tx_en, 0);
        chk("mid_rst_empty", empty, 1);
        rst_n = 1'b1;
        step();
        chk("mid_rst_idle", tx_en, 0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            wr_en    = ($urandom_range(0, 99) < ((c / 200) % 2 == 0 ? 30 : 70));
            wr_data  = 8'($urandom);
            ucsz     = 4'($urandom_range(3, 10));
            if ($urandom_range(0, 3) == 0) tx_ready = ~tx_ready;
            rst_n    = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
